// File: rtl/mips_cache_pkg.sv
// Shared definitions for the MIPS fetch-path caches: FSM states and
// elaboration-time sizing helpers.
package mips_cache_pkg;

  typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, RESP} state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int beats(input int line_w, input int mem_w);
    return line_w / mem_w;
  endfunction

endpackage

// File: rtl/icache_refill.sv
// Line refill engine: walks the beats of one line over the req/ack port
// and assembles them LSB-first; done pulses with the final ack.
module icache_refill
  import mips_cache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128,
  parameter int MEM_W  = 32,
  localparam int OFF   = clog2(LINE_W / 8)
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  start,
  input  logic [ADDR_W-OFF-1:0] line_addr,
  input  logic                  mem_ack,
  input  logic [MEM_W-1:0]      mem_data,
  output logic                  mem_req,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [LINE_W-1:0]     fill,
  output logic [LINE_W-1:0]     line,
  output logic                  done
);

  localparam int BEATS = beats(LINE_W, MEM_W);
  localparam int BW    = clog2(BEATS) + 1;

  logic                  active;
  logic [BW-1:0]         beat;
  logic [ADDR_W-OFF-1:0] base_q;
  logic [OFF-1:0]        off;
  logic                  take, last;

  assign take    = active & mem_ack;
  assign last    = (beat == BW'(BEATS - 1));
  assign done    = take & last;
  assign mem_req = active;
  // Offset stays inside the line field, so the beat address never carries into the tag.
  assign off      = OFF'(int'(beat) * (MEM_W / 8));
  assign mem_addr = active ? {base_q, off} : '0;

  generate
    if (BEATS == 1) begin : g_single
      assign fill = mem_data;
    end else begin : g_shift
      assign fill = {mem_data, line[LINE_W-1:MEM_W]};
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (!nreset) begin
      active <= 1'b0;
      beat   <= '0;
      base_q <= '0;
      line   <= '0;
    end else if (start) begin
      active <= 1'b1;
      beat   <= '0;
      base_q <= line_addr;
    end else if (take) begin
      line <= fill;
      beat <= beat + BW'(1);
      if (last) active <= 1'b0;
    end
  end

endmodule

// File: rtl/i_cache_dm.sv
// Direct-mapped instruction cache, one full line per accepted fetch.
// Optional hit/miss counters under `define ICACHE_STATS_EN.
module i_cache_dm
  import mips_cache_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 128,
  parameter int INDEX_W = 5,
  parameter int MEM_W   = 32
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              flush,
  output logic              ready,
  output logic              dout_valid,
  output logic [LINE_W-1:0] dout,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [MEM_W-1:0]  mem_data
`ifdef ICACHE_STATS_EN
  , output logic [31:0]     hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int OFF   = clog2(LINE_W / 8);
  localparam int TAG_W = ADDR_W - OFF - INDEX_W;
  localparam int LINES = 1 << INDEX_W;

  state_t state, state_nxt;

  logic [TAG_W-1:0]   tag_ram  [LINES];
  logic [LINE_W-1:0]  data_ram [LINES];
  logic [LINES-1:0]   valid;
  logic [TAG_W-1:0]   rd_tag, tag_q, pc_tag;
  logic [LINE_W-1:0]  rd_data, fill, line;
  logic [INDEX_W-1:0] idx_q, pc_idx;
  logic flush_q, hit, rd_acc, flush_acc, refill_start, refill_done;
  logic unused_pc_lo;

  assign pc_idx       = pc_in[OFF +: INDEX_W];
  assign pc_tag       = pc_in[ADDR_W-1 -: TAG_W];
  assign unused_pc_lo = ^pc_in[OFF-1:0];

  assign hit       = (state == LOOKUP) && valid[idx_q] && (rd_tag == tag_q);
  // flush_q holds ready low for the cycle after a flush is taken.
  assign ready     = nreset && !flush_q && ((state == IDLE) || hit);
  assign flush_acc = flush & ready;
  assign rd_acc    = rd_en & ready & ~flush;

  always_comb begin
    state_nxt    = state;
    refill_start = 1'b0;
    dout_valid   = 1'b0;
    dout         = '0;
    case (state)
      IDLE:   if (rd_acc) state_nxt = LOOKUP;
      LOOKUP: begin
        if (hit) begin
          dout_valid = 1'b1;
          dout       = rd_data;
          state_nxt  = rd_acc ? LOOKUP : IDLE;
        end else begin
          refill_start = 1'b1;
          state_nxt    = REFILL;
        end
      end
      REFILL: if (refill_done) state_nxt = RESP;
      RESP: begin
        dout_valid = 1'b1;
        dout       = line;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      state   <= IDLE;
      flush_q <= 1'b0;
      valid   <= '0;
      tag_q   <= '0;
      idx_q   <= '0;
    end else begin
      state   <= state_nxt;
      flush_q <= flush_acc;
      if (flush_acc) valid <= '0;
      else if (refill_done) valid[idx_q] <= 1'b1;
      if (rd_acc) begin
        tag_q <= pc_tag;
        idx_q <= pc_idx;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (refill_done) begin
      tag_ram[idx_q]  <= tag_q;
      data_ram[idx_q] <= fill;
    end
    if (rd_acc) begin
      rd_tag  <= tag_ram[pc_idx];
      rd_data <= data_ram[pc_idx];
    end
  end

  icache_refill #(
    .ADDR_W (ADDR_W),
    .LINE_W (LINE_W),
    .MEM_W  (MEM_W)
  ) u_refill (
    .clock     (clock),
    .nreset    (nreset),
    .start     (refill_start),
    .line_addr ({tag_q, idx_q}),
    .mem_ack   (mem_ack),
    .mem_data  (mem_data),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .fill      (fill),
    .line      (line),
    .done      (refill_done)
  );

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clock) begin
    if (!nreset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == LOOKUP) begin
      if (hit && hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
      if (!hit && miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule
